// File: rtl/fsm_stim_seq.sv
// fsm_stim_seq: plays a table of {A,B} steps into the two-input Moore fsm,
//    each step held hold+1 cycles, and counts Q high cycles and Q rising edges.
// Latency: start at edge 0 -> fsm_reset for RST_CYC cycles -> sum(hold+1) RUN
//    cycles -> done pulse after edge RST_CYC+sum+1. No backpressure: start and
//    cfg_we are dropped while busy, and abort ends a run on the next edge.
// Ports: clk/reset (sync, active high); cfg_we/cfg_addr/cfg_a/cfg_b/cfg_hold
//    write one step slot while idle; start/num_steps launch a run; abort ends a
//    run; q is the fsm output. Outputs: fsm_reset/a/b drive the fsm, busy/done/err
//    give status, q_high_cnt/q_rise_cnt hold the Q statistics. All outputs are
//    registered.
module fsm_stim_seq #(
   parameter int DEPTH   = 8,
   parameter int HOLD_W  = 4,
   parameter int CNT_W   = 8,
   parameter int RST_CYC = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cfg_we,
   input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
   input  logic                       cfg_a,
   input  logic                       cfg_b,
   input  logic [HOLD_W-1:0]          cfg_hold,
   input  logic                       start,
   input  logic [$clog2(DEPTH):0]     num_steps,
   input  logic                       abort,
   input  logic                       q,
   output logic                       fsm_reset,
   output logic                       a,
   output logic                       b,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic [CNT_W-1:0]           q_high_cnt,
   output logic [CNT_W-1:0]           q_rise_cnt
);

   localparam int AW  = $clog2(DEPTH);
   localparam int NW  = AW + 1;
   localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

   typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;

   typedef struct packed {
      logic              a;
      logic              b;
      logic [HOLD_W-1:0] hold;
   } step_t;

   state_t            state;
   step_t             tbl [DEPTH];
   logic [RCW-1:0]    rst_cnt;
   logic [AW-1:0]     step;
   logic [NW-1:0]     steps_n;
   logic [HOLD_W-1:0] hold_cnt;
   logic              q_prev;

   logic [AW-1:0]     step_nxt;
   logic              last_step;
   logic              start_ok;

   assign step_nxt  = step + AW'(1);
   assign last_step = ({1'b0, step} == (steps_n - NW'(1)));
   assign start_ok  = (num_steps != '0) && (num_steps <= NW'(DEPTH));

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         fsm_reset  <= 1'b1;
         a          <= 1'b0;
         b          <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         q_high_cnt <= '0;
         q_rise_cnt <= '0;
         q_prev     <= 1'b0;
         rst_cnt    <= '0;
         step       <= '0;
         steps_n    <= '0;
         hold_cnt   <= '0;
         for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (abort && (state == RST || state == RUN)) begin
            // Abort wins over step advance and completion; counters keep
            // whatever they held before this edge.
            state     <= IDLE;
            fsm_reset <= 1'b0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  fsm_reset <= 1'b0;
                  a         <= 1'b0;
                  b         <= 1'b0;
                  busy      <= 1'b0;
                  if (cfg_we) tbl[cfg_addr] <= {cfg_a, cfg_b, cfg_hold};
                  if (start) begin
                     if (start_ok) begin
                        steps_n    <= num_steps;
                        q_high_cnt <= '0;
                        q_rise_cnt <= '0;
                        q_prev     <= 1'b0;
                        rst_cnt    <= '0;
                        busy       <= 1'b1;
                        fsm_reset  <= 1'b1;
                        state      <= RST;
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
               RST: begin
                  if (rst_cnt == RCW'(RST_CYC - 1)) begin
                     state     <= RUN;
                     fsm_reset <= 1'b0;
                     step      <= '0;
                     hold_cnt  <= tbl[0].hold;
                     a         <= tbl[0].a;
                     b         <= tbl[0].b;
                  end else begin
                     rst_cnt <= rst_cnt + RCW'(1);
                  end
               end
               RUN: begin
                  // Saturating statistics over the q seen in this RUN cycle.
                  if (q && (q_high_cnt != {CNT_W{1'b1}}))
                     q_high_cnt <= q_high_cnt + CNT_W'(1);
                  if (q && !q_prev && (q_rise_cnt != {CNT_W{1'b1}}))
                     q_rise_cnt <= q_rise_cnt + CNT_W'(1);
                  q_prev <= q;
                  if (hold_cnt == '0) begin
                     if (last_step) begin
                        state <= DONE;
                        a     <= 1'b0;
                        b     <= 1'b0;
                        busy  <= 1'b0;
                     end else begin
                        step     <= step_nxt;
                        hold_cnt <= tbl[step_nxt].hold;
                        a        <= tbl[step_nxt].a;
                        b        <= tbl[step_nxt].b;
                     end
                  end else begin
                     hold_cnt <= hold_cnt - HOLD_W'(1);
                  end
               end
               DONE: begin
                  // done is registered on the way out of DONE, so the pulse
                  // lands one edge after the last RUN cycle has been closed.
                  done  <= 1'b1;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fsm_stim_seq.sv
module tb_fsm_stim_seq;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       reset, cfg_we, cfg_a, cfg_b, start, abort, q;
   logic [2:0] cfg_addr;
   logic [3:0] cfg_hold;
   logic [3:0] num_steps;

   logic       fsm_reset, a, b, busy, done, err;
   logic [7:0] q_high_cnt, q_rise_cnt;

   logic       s_fsm_reset, s_a, s_b, s_busy, s_done, s_err;
   logic [1:0] s_high, s_rise;

   logic [1:0] exp_ab [4];
   logic       qv [5];

   fsm_stim_seq u_dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_hold(cfg_hold), .start(start),
      .num_steps(num_steps), .abort(abort), .q(q),
      .fsm_reset(fsm_reset), .a(a), .b(b), .busy(busy), .done(done),
      .err(err), .q_high_cnt(q_high_cnt), .q_rise_cnt(q_rise_cnt)
   );

   fsm_stim_seq #(.CNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_hold(cfg_hold), .start(start),
      .num_steps(num_steps), .abort(abort), .q(q),
      .fsm_reset(s_fsm_reset), .a(s_a), .b(s_b), .busy(s_busy), .done(s_done),
      .err(s_err), .q_high_cnt(s_high), .q_rise_cnt(s_rise)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] ad, input logic va, input logic vb, input logic [3:0] h);
      cfg_we = 1'b1; cfg_addr = ad; cfg_a = va; cfg_b = vb; cfg_hold = h;
      tick;
      cfg_we = 1'b0;
   endtask

   task automatic go(input logic [3:0] n);
      start = 1'b1; num_steps = n;
      tick;
      start = 1'b0;
   endtask

   initial begin
      exp_ab = '{2'b10, 2'b01, 2'b01, 2'b00};
      qv     = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      reset = 1'b1; cfg_we = 1'b0; cfg_a = 1'b0; cfg_b = 1'b0; start = 1'b0;
      abort = 1'b0; q = 1'b0; cfg_addr = '0; cfg_hold = '0; num_steps = '0;

      // Reset state
      tick; tick;
      chk("rst_fsm_reset", fsm_reset, 1);
      chk("rst_ab", {a, b}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_high", q_high_cnt, 0);
      chk("rst_rise", q_rise_cnt, 0);
      reset = 1'b0;
      tick;
      chk("idle_fsm_reset", fsm_reset, 0);

      // Basic run: 4 single-cycle steps
      wr(0, 1, 0, 0); wr(1, 0, 1, 0); wr(2, 0, 1, 0); wr(3, 0, 0, 0);
      go(4);
      chk("basic_rst_busy", busy, 1);
      chk("basic_rst_fsm_reset", fsm_reset, 1);
      chk("basic_rst_ab", {a, b}, 0);
      for (int i = 1; i <= 4; i++) begin
         tick;
         chk("basic_ab", {a, b}, exp_ab[i-1]);
         chk("basic_busy", busy, 1);
         chk("basic_fsm_reset", fsm_reset, 0);
      end
      tick;
      chk("basic_busy_end", busy, 0);
      chk("basic_done_early", done, 0);
      tick;
      chk("basic_done", done, 1);
      tick;
      chk("basic_done_pulse", done, 0);

      // Hold timing
      wr(0, 1, 1, 3); wr(1, 0, 1, 1);
      go(2);
      for (int i = 1; i <= 6; i++) begin
         tick;
         chk("hold_ab", {a, b}, (i <= 4) ? 2'b11 : 2'b01);
      end
      tick;
      chk("hold_done_early", done, 0);
      chk("hold_busy_end", busy, 0);
      tick;
      chk("hold_done", done, 1);
      tick;

      // Q statistics over a 5-cycle RUN
      wr(0, 0, 0, 4);
      go(1);
      tick;
      for (int i = 0; i < 5; i++) begin
         q = qv[i];
         tick;
      end
      q = 1'b0;
      chk("stat_high", q_high_cnt, 3);
      chk("stat_rise", q_rise_cnt, 2);
      tick;
      chk("stat_done", done, 1);

      // Illegal starts
      go(0);
      chk("ill0_err", err, 1);
      chk("ill0_busy", busy, 0);
      chk("ill0_high", q_high_cnt, 3);
      chk("ill0_rise", q_rise_cnt, 2);
      tick;
      chk("ill0_err_pulse", err, 0);
      go(9);
      chk("ill9_err", err, 1);
      chk("ill9_busy", busy, 0);

      // Legal start clears counters; start/cfg_we during RUN ignored
      go(1);
      chk("clr_high", q_high_cnt, 0);
      chk("clr_rise", q_rise_cnt, 0);
      tick;
      cfg_we = 1'b1; cfg_addr = 0; cfg_a = 1'b1; cfg_b = 1'b1; cfg_hold = 0;
      start = 1'b1; num_steps = 0;
      tick;
      cfg_we = 1'b0; start = 1'b0;
      chk("ign_err", err, 0);
      chk("ign_busy", busy, 1);
      chk("ign_ab", {a, b}, 0);
      tick; tick; tick; tick;
      chk("ign_busy_end", busy, 0);
      tick;
      chk("ign_done", done, 1);
      tick;

      // Replay shows slot 0 unchanged ({0,0,hold 4})
      go(1);
      for (int i = 1; i <= 5; i++) begin
         tick;
         chk("replay_ab", {a, b}, 0);
         chk("replay_busy", busy, 1);
      end
      tick;
      chk("replay_done_early", done, 0);
      tick;
      chk("replay_done", done, 1);
      tick;

      // Abort on RUN cycle 2 of a 4-step run
      wr(0, 1, 0, 0);
      go(4);
      tick;
      q = 1'b1;
      tick;
      chk("abort_ab_run2", {a, b}, 2'b01);
      q = 1'b0; abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_ab", {a, b}, 0);
      chk("abort_fsm_reset", fsm_reset, 0);
      chk("abort_high", q_high_cnt, 1);
      chk("abort_rise", q_rise_cnt, 1);
      q = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("abort_no_done", done, 0);
         tick;
      end
      q = 1'b0;
      chk("abort_high_hold", q_high_cnt, 1);
      chk("abort_rise_hold", q_rise_cnt, 1);

      // Saturation: q=1 for 6 RUN cycles
      wr(0, 1, 1, 5);
      go(1);
      q = 1'b1;
      tick;
      for (int i = 0; i < 6; i++) tick;
      q = 1'b0;
      chk("sat_high8", q_high_cnt, 6);
      chk("sat_rise8", q_rise_cnt, 1);
      chk("sat_high2", s_high, 3);
      chk("sat_rise2", s_rise, 1);
      tick;
      chk("sat_done", done, 1);
      chk("sat_done2", s_done, 1);
      tick;

      // Reset mid-run clears outputs, counters and the table
      go(1);
      q = 1'b1;
      tick; tick;
      chk("mid_ab", {a, b}, 2'b11);
      reset = 1'b1;
      tick;
      reset = 1'b0; q = 1'b0;
      chk("mid_fsm_reset", fsm_reset, 1);
      chk("mid_ab_rst", {a, b}, 0);
      chk("mid_busy", busy, 0);
      chk("mid_high", q_high_cnt, 0);
      chk("mid_rise", q_rise_cnt, 0);
      chk("mid_high2", s_high, 0);
      tick;
      go(1);
      tick;
      chk("cleared_ab", {a, b}, 0);
      chk("cleared_busy", busy, 1);
      tick;
      chk("cleared_busy_end", busy, 0);
      tick;
      chk("cleared_done", done, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
